// File: rtl/mmc_apb_pkg.sv
// Shared types and constants for the MMC APB master arbiter.
// Holds the transfer FSM encoding, default bus widths and the word-alignment check.
package mmc_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int TO_CNT_W    = 8;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mmc_rr_arb.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module mmc_rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NREQ);
      if (enable && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmc_apb_arb.sv
// Round-robin APB3 master arbiter for the MMC control register bank.
// One transfer at a time: IDLE -> SETUP -> ACCESS (wait/timeout) -> RESP.
module mmc_apb_arb
  import mmc_apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   m_psel,
  output logic                   m_penable,
  output logic                   m_pwrite,
  output logic [ADDR_W-1:0]      m_paddr,
  output logic [DATA_W-1:0]      m_pwdata,
  input  logic [DATA_W-1:0]      m_prdata,
  input  logic                   m_pready
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0]    LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(TIMEOUT - 1);
  localparam logic [TO_CNT_W-1:0] TO_MAX   = '1;

  state_t                state_reg;
  logic [IDX_W-1:0]      gidx_reg;
  logic [IDX_W-1:0]      last_grant_reg;
  logic [TO_CNT_W-1:0]   to_cnt_reg;

  logic [ADDR_W-1:0]     addr_arr  [NREQ];
  logic [DATA_W-1:0]     wdata_arr [NREQ];
  logic [NREQ-1:0]       grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  mmc_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .enable     (state_reg == ST_IDLE),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Acceptance is visible in the same IDLE cycle so the requester can drop valid right after.
  assign req_ready = grant;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg      <= ST_IDLE;
      gidx_reg       <= '0;
      last_grant_reg <= LAST_RST;
      to_cnt_reg     <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      m_psel         <= 1'b0;
      m_penable      <= 1'b0;
      m_pwrite       <= 1'b0;
      m_paddr        <= '0;
      m_pwdata       <= '0;
    end else begin
      rsp_valid <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            last_grant_reg <= grant_idx;
            gidx_reg       <= grant_idx;
            m_pwrite       <= req_write[grant_idx];
            m_paddr        <= addr_arr[grant_idx];
            m_pwdata       <= wdata_arr[grant_idx];
            // Misaligned requests never reach the bus; answer straight away.
            if (is_misaligned(addr_arr[grant_idx][1:0])) begin
              state_reg <= ST_RESP;
              rsp_valid <= grant;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_reg <= ST_SETUP;
              m_psel    <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state_reg  <= ST_ACCESS;
          m_penable  <= 1'b1;
          to_cnt_reg <= '0;
        end
        ST_ACCESS: begin
          if (m_pready) begin
            state_reg <= ST_RESP;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            rsp_valid <= NREQ'(1) << gidx_reg;
            rsp_err   <= 1'b0;
            rsp_rdata <= m_pwrite ? '0 : m_prdata;
          end else if (to_cnt_reg >= TO_LAST) begin
            // Slave left hanging; the bus is released regardless.
            state_reg <= ST_RESP;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            rsp_valid <= NREQ'(1) << gidx_reg;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (to_cnt_reg != TO_MAX) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmc_apb_arb.sv
// Self-checking bench for mmc_apb_arb: directed scenarios plus randomized traffic
// checked against a round-robin / latency / memory reference model.
module tb_mmc_apb_arb;

  localparam int NREQ    = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic               pclk;
  logic               presetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               m_psel;
  logic               m_penable;
  logic               m_pwrite;
  logic [AW-1:0]      m_paddr;
  logic [DW-1:0]      m_pwdata;
  logic [DW-1:0]      m_prdata = '0;
  logic               m_pready = 1'b0;

  int total = 0;
  int bad   = 0;

  // slave behaviour knobs
  int          slave_waits = 0;
  bit          rd_ovr_en   = 0;
  logic [31:0] rd_ovr_val  = '0;
  int          acc_cnt     = 0;
  logic [31:0] slave_mem [16];

  // reference model state
  int          model_last;
  logic [31:0] model_mem [16];

  mmc_apb_arb #(
    .NREQ    (NREQ),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // APB slave: ready after slave_waits ACCESS cycles, garbage read data outside ACCESS
  always @(negedge pclk) begin
    if (m_psel && m_penable) begin
      m_pready = (acc_cnt >= slave_waits);
      m_prdata = rd_ovr_en ? rd_ovr_val : slave_mem[m_paddr[5:2]];
      acc_cnt  = acc_cnt + 1;
    end else begin
      m_pready = 1'b0;
      m_prdata = $urandom();
      acc_cnt  = 0;
    end
  end

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 16; i++) slave_mem[i] <= '0;
    end else if (m_psel && m_penable && m_pready && m_pwrite) begin
      slave_mem[m_paddr[5:2]] <= m_pwdata;
    end
  end

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0 && i < NREQ) v[i] = 1'b1;
    return v;
  endfunction

  // round-robin rule: first pending index after the last grant, wrapping
  function automatic int model_next(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int model_lat(input bit misal, input int waits);
    if (misal) return 1;
    if (waits < TIMEOUT) return 3 + waits;
    return TIMEOUT + 2;
  endfunction

  task automatic model_clear();
    model_last = NREQ - 1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
  endtask

  task automatic set_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_ready(output logic [NREQ-1:0] seen);
    seen = '0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready !== '0) begin
        seen = req_ready;
        return;
      end
      @(negedge pclk);
    end
  endtask

  // Follows one accepted transfer from cycle 1 until its response (or a 300-cycle bound).
  task automatic follow(input logic [31:0] a, input logic [31:0] d, input bit wr, input int drop_idx,
                        output int lat, output logic [NREQ-1:0] rv, output logic [31:0] rd,
                        output bit er, output int setup_at, output int access_at, output int acc_n,
                        output bit stable, output bit psel_seen, output bit psel_at_rsp);
    lat = -1; rv = '0; rd = '0; er = 1'b0; setup_at = -1; access_at = -1; acc_n = 0;
    stable = 1'b1; psel_seen = 1'b0; psel_at_rsp = 1'b1;
    for (int t = 1; t <= 300; t++) begin
      @(negedge pclk); #1;
      if (t == 1 && drop_idx >= 0) req_valid[drop_idx] = 1'b0;
      if (m_psel) psel_seen = 1'b1;
      if (m_psel && !m_penable && setup_at < 0) setup_at = t;
      if (m_psel && m_penable) begin
        acc_n++;
        if (access_at < 0) access_at = t;
      end
      if (m_psel && (m_paddr !== a || m_pwdata !== d || m_pwrite !== wr)) stable = 1'b0;
      if (rsp_valid !== '0) begin
        lat = t; rv = rsp_valid; rd = rsp_rdata; er = rsp_err; psel_at_rsp = m_psel;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [2*DW+AW+2*NREQ+4-1:0] outs;
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    outs = {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, rsp_valid, rsp_rdata, rsp_err, req_ready};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    presetn = 1'b1;
    model_clear();
    @(negedge pclk); #1;
    $display("test_reset: outputs=%h", outs);
  endtask

  task automatic test_single_read();
    logic [NREQ-1:0] seen, rv;
    logic [31:0] rd;
    int lat, s_at, a_at, acc_n, g;
    bit er, st, ps, pr;
    rd_ovr_en = 1; rd_ovr_val = 32'hFFFF_FFFF; slave_waits = 0;
    g = model_next(3'b001, model_last);
    set_req(0, 1'b0, 32'h4, 32'h0);
    wait_ready(seen);
    model_last = g;
    total++;
    if (seen !== onehot(g)) begin bad++; $display("FAIL read_grant: got %b want %b", seen, onehot(g)); end
    follow(32'h4, 32'h0, 1'b0, 0, lat, rv, rd, er, s_at, a_at, acc_n, st, ps, pr);
    total++; if (s_at != 1) begin bad++; $display("FAIL read_setup_cycle: got %0d want 1", s_at); end
    total++; if (a_at != 2) begin bad++; $display("FAIL read_access_cycle: got %0d want 2", a_at); end
    total++; if (lat != 3) begin bad++; $display("FAIL read_rsp_cycle: got %0d want 3", lat); end
    total++; if (rv !== 3'b001) begin bad++; $display("FAIL read_rsp_valid: got %b want 001", rv); end
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL read_rdata: got %h want ffffffff", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL read_err: got %b want 0", er); end
    rd_ovr_en = 0;
    $display("test_single_read: lat=%0d rdata=%h err=%b", lat, rd, er);
  endtask

  task automatic test_write_wait();
    logic [NREQ-1:0] seen, rv;
    logic [31:0] rd;
    int lat, s_at, a_at, acc_n, g;
    bit er, st, ps, pr;
    slave_waits = 3;
    g = model_next(3'b010, model_last);
    set_req(1, 1'b1, 32'h8, 32'h1234_5678);
    wait_ready(seen);
    model_last = g;
    total++;
    if (seen !== onehot(g)) begin bad++; $display("FAIL write_grant: got %b want %b", seen, onehot(g)); end
    follow(32'h8, 32'h1234_5678, 1'b1, 1, lat, rv, rd, er, s_at, a_at, acc_n, st, ps, pr);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL write_bus_stable: got %b want 1", st); end
    total++; if (acc_n != 4) begin bad++; $display("FAIL write_access_cycles: got %0d want 4", acc_n); end
    total++; if (lat != 6) begin bad++; $display("FAIL write_rsp_cycle: got %0d want 6", lat); end
    total++; if (rv !== 3'b010) begin bad++; $display("FAIL write_rsp_valid: got %b want 010", rv); end
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL write_rsp: got rdata=%h err=%b want 0/0", rd, er); end
    model_mem[2] = 32'h1234_5678;
    slave_waits = 0;
    $display("test_write_wait: lat=%0d access=%0d stable=%b", lat, acc_n, st);
  endtask

  task automatic test_contention();
    int gcnt;
    int gcyc [4];
    logic [NREQ-1:0] gv [4];
    logic [NREQ-1:0] expv;
    slave_waits = 0;
    gcnt = 0;
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 32'h14, 32'h0);
    #1;
    for (int t = 0; t < 40 && gcnt < 4; t++) begin
      if (req_ready !== '0) begin
        gv[gcnt] = req_ready; gcyc[gcnt] = t; gcnt++;
      end
      @(negedge pclk); #1;
    end
    req_valid = '0;
    total++;
    if (gcnt != 4) begin bad++; $display("FAIL contention_grant_count: got %0d want 4", gcnt); end
    for (int k = 0; k < gcnt; k++) begin
      expv = onehot(model_next(3'b011, model_last));
      model_last = model_next(3'b011, model_last);
      total++;
      if (gv[k] !== expv) begin bad++; $display("FAIL contention_order[%0d]: got %b want %b", k, gv[k], expv); end
      if (k > 0) begin
        total++;
        if (gcyc[k] - gcyc[k-1] != 4) begin
          bad++; $display("FAIL contention_spacing[%0d]: got %0d want 4", k, gcyc[k] - gcyc[k-1]);
        end
      end
      $display("test_contention: grant %0d = %b at cycle %0d", k, gv[k], gcyc[k]);
    end
    repeat (5) @(negedge pclk);
    #1;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] seen, rv;
    logic [31:0] rd;
    int lat, s_at, a_at, acc_n, g;
    bit er, st, ps, pr;
    slave_waits = 1000;
    g = model_next(3'b100, model_last);
    set_req(2, 1'b0, 32'hC, 32'h0);
    wait_ready(seen);
    model_last = g;
    total++;
    if (seen !== onehot(g)) begin bad++; $display("FAIL timeout_grant: got %b want %b", seen, onehot(g)); end
    follow(32'hC, 32'h0, 1'b0, 2, lat, rv, rd, er, s_at, a_at, acc_n, st, ps, pr);
    total++; if (acc_n != TIMEOUT) begin bad++; $display("FAIL timeout_access_cycles: got %0d want %0d", acc_n, TIMEOUT); end
    total++; if (lat != TIMEOUT + 2) begin bad++; $display("FAIL timeout_rsp_cycle: got %0d want %0d", lat, TIMEOUT + 2); end
    total++; if (pr !== 1'b0) begin bad++; $display("FAIL timeout_psel_drop: got %b want 0", pr); end
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL timeout_rsp: got err=%b rdata=%h want 1/0", er, rd); end
    total++; if (rv !== 3'b100) begin bad++; $display("FAIL timeout_rsp_valid: got %b want 100", rv); end
    slave_waits = 0;
    $display("test_timeout: access=%0d lat=%0d err=%b", acc_n, lat, er);
  endtask

  task automatic test_misaligned();
    logic [NREQ-1:0] seen, rv;
    logic [31:0] rd;
    int lat, s_at, a_at, acc_n, g;
    bit er, st, ps, pr;
    g = model_next(3'b001, model_last);
    set_req(0, 1'b0, 32'h6, 32'h0);
    wait_ready(seen);
    model_last = g;
    total++;
    if (seen !== onehot(g)) begin bad++; $display("FAIL misal_grant: got %b want %b", seen, onehot(g)); end
    follow(32'h6, 32'h0, 1'b0, 0, lat, rv, rd, er, s_at, a_at, acc_n, st, ps, pr);
    total++; if (lat != 1) begin bad++; $display("FAIL misal_rsp_cycle: got %0d want 1", lat); end
    total++; if (rv !== 3'b001 || er !== 1'b1) begin bad++; $display("FAIL misal_rsp: got valid=%b err=%b want 001/1", rv, er); end
    total++; if (ps !== 1'b0) begin bad++; $display("FAIL misal_no_psel: got %b want 0", ps); end
    $display("test_misaligned: lat=%0d err=%b psel_seen=%b", lat, er, ps);
  endtask

  task automatic test_reset_mid_access();
    logic [NREQ-1:0] seen, rv;
    logic [31:0] rd;
    logic [2*DW+AW+NREQ+4-1:0] outs;
    int lat, s_at, a_at, acc_n;
    bit er, st, ps, pr, rsp_seen;
    slave_waits = 1000;
    set_req(0, 1'b0, 32'h20, 32'h0);
    wait_ready(seen);
    @(negedge pclk); #1;
    req_valid[0] = 1'b0;
    @(negedge pclk); #1;
    total++;
    if (m_penable !== 1'b1) begin bad++; $display("FAIL rst_mid_in_access: got penable=%b want 1", m_penable); end
    presetn = 1'b0;
    #1;
    outs = {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, rsp_valid, rsp_rdata, rsp_err};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
    rsp_seen = 1'b0;
    repeat (3) begin
      @(negedge pclk); #1;
      if (rsp_valid !== '0) rsp_seen = 1'b1;
    end
    presetn = 1'b1;
    model_clear();
    slave_waits = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge pclk); #1;
      if (rsp_valid !== '0) rsp_seen = 1'b1;
    end
    total++;
    if (rsp_seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_rsp: got %b want 0", rsp_seen); end
    set_req(0, 1'b0, 32'h24, 32'h0);
    set_req(1, 1'b0, 32'h28, 32'h0);
    wait_ready(seen);
    total++;
    if (seen !== onehot(model_next(3'b011, model_last))) begin
      bad++; $display("FAIL rst_mid_first_grant: got %b want %b", seen, onehot(model_next(3'b011, model_last)));
    end
    model_last = model_next(3'b011, model_last);
    follow(32'h24, 32'h0, 1'b0, 0, lat, rv, rd, er, s_at, a_at, acc_n, st, ps, pr);
    wait_ready(seen);
    total++;
    if (seen !== onehot(model_next(3'b010, model_last))) begin
      bad++; $display("FAIL rst_mid_second_grant: got %b want %b", seen, onehot(model_next(3'b010, model_last)));
    end
    model_last = model_next(3'b010, model_last);
    follow(32'h28, 32'h0, 1'b0, 1, lat, rv, rd, er, s_at, a_at, acc_n, st, ps, pr);
    total++;
    if (rv !== 3'b010 || er !== 1'b0) begin bad++; $display("FAIL rst_mid_second_rsp: got valid=%b err=%b want 010/0", rv, er); end
    $display("test_reset_mid_access: outs=%h rsp_during_reset=%b", outs, rsp_seen);
  endtask

  task automatic test_random();
    bit          pend [NREQ];
    bit          pw   [NREQ];
    logic [31:0] pa   [NREQ];
    logic [31:0] pd   [NREQ];
    logic [NREQ-1:0] pmask, seen, rv;
    logic [31:0] rd, exp_rd;
    int lat, s_at, a_at, acc_n, g, waits, widx, exp_lat;
    bit er, st, ps, pr, misal, exp_err;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      pmask = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || (i == NREQ - 1 && pmask == '0))) begin
          widx  = int'($urandom_range(0, 15));
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = 32'(widx * 4);
          if ($urandom_range(0, 7) == 0) pa[i] = pa[i] + 32'($urandom_range(1, 3));
          pd[i] = $urandom();
          set_req(i, pw[i], pa[i], pd[i]);
          pend[i] = 1'b1;
        end
        if (pend[i]) pmask[i] = 1'b1;
      end
      waits = int'($urandom_range(0, 5));
      slave_waits = waits;
      g = model_next(pmask, model_last);
      wait_ready(seen);
      total++;
      if (seen !== onehot(g)) begin bad++; $display("FAIL rand_grant[%0d]: got %b want %b", it, seen, onehot(g)); end
      model_last = g;
      pend[g] = 1'b0;
      misal   = (pa[g][1:0] != 2'b00);
      exp_err = misal || (waits >= TIMEOUT);
      exp_lat = model_lat(misal, waits);
      exp_rd  = (exp_err || pw[g]) ? 32'h0 : model_mem[pa[g][5:2]];
      follow(pa[g], pd[g], pw[g], g, lat, rv, rd, er, s_at, a_at, acc_n, st, ps, pr);
      total++;
      if (lat != exp_lat) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, exp_lat); end
      total++;
      if (rv !== onehot(g)) begin bad++; $display("FAIL rand_rsp_valid[%0d]: got %b want %b", it, rv, onehot(g)); end
      total++;
      if (er !== exp_err) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", it, er, exp_err); end
      total++;
      if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", it, rd, exp_rd); end
      total++;
      if (st !== 1'b1) begin bad++; $display("FAIL rand_bus_stable[%0d]: got %b want 1", it, st); end
      if (!exp_err && pw[g]) model_mem[pa[g][5:2]] = pd[g];
      $display("test_random[%0d]: req=%0d wr=%b addr=%h waits=%0d lat=%0d err=%b rdata=%h",
               it, g, pw[g], pa[g], waits, lat, er, rd);
    end
  endtask

  initial begin
    presetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    model_clear();
    test_reset();
    test_single_read();
    test_write_wait();
    test_contention();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
